// File: rtl/mem_responder_if.sv
// Byte-wide core bus plus the TX byte stream served by mem_responder.
// master = core/sink side, slave = responder side.
interface mem_responder_if;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [31:0] mem_din;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic        io_full;

  modport master (
    output rdy, mem_a, mem_dout, mem_wr, io_tx_ready,
    input  mem_din, io_tx_data, io_tx_valid, io_full
  );

  modport slave (
    input  rdy, mem_a, mem_dout, mem_wr, io_tx_ready,
    output mem_din, io_tx_data, io_tx_valid, io_full
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: byte RAM, IO window at 0x30000 with a TX FIFO drained to a byte sink.
// Optional access counters when MEM_RESP_STATS_EN is defined.
module mem_responder #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_RESP_STATS_EN
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
`endif
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]        ram [2**ADDR_W];
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       io_off;
  logic              is_io;
  logic              ram_wr, ram_rd, io_wr, io_rd;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [31:0]       io_rdata;
  logic              unused_addr_bits;

  assign idx    = bus.mem_a[ADDR_W-1:0];
  assign io_off = bus.mem_a[15:0];
  assign is_io  = (bus.mem_a[17:16] == 2'b11);
  assign unused_addr_bits = ^bus.mem_a[31:18];

  assign ram_wr = bus.rdy &  bus.mem_wr & ~is_io;
  assign ram_rd = bus.rdy & ~bus.mem_wr & ~is_io;
  assign io_wr  = bus.rdy &  bus.mem_wr &  is_io;
  assign io_rd  = bus.rdy & ~bus.mem_wr &  is_io;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Full is judged before the edge, so a same-cycle pop never rescues a push.
  assign push = io_wr && (io_off == 16'h0000) && !fifo_full;
  assign pop  = !fifo_empty && bus.io_tx_ready;

  assign bus.io_tx_valid = !fifo_empty;
  assign bus.io_full     = fifo_full;
  assign bus.io_tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];

  always_comb begin
    io_rdata = '0;
    case (io_off)
      16'h0004: io_rdata = {30'b0, fifo_full, fifo_empty};
`ifdef MEM_RESP_STATS_EN
      16'h0008: io_rdata = stat_rd_cnt;
      16'h000C: io_rdata = stat_wr_cnt;
`endif
      default:  io_rdata = '0;
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[idx] <= bus.mem_dout;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.mem_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_din <= '0;
    end else if (ram_rd) begin
      bus.mem_din <= {24'b0, ram[idx]};
    end else if (io_rd) begin
      bus.mem_din <= io_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (ram_rd) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (ram_wr) stat_wr_cnt <= stat_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios followed by random bus/sink traffic
// compared against a queue-based reference model.
module tb_mem_responder;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 16;
`ifdef MEM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus();

`ifdef MEM_RESP_STATS_EN
  logic [31:0] stat_rd_cnt, stat_wr_cnt;
`endif

  mem_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MEM_RESP_STATS_EN
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt),
`endif
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram_m [int];
  logic [7:0]  q [$];
  logic [7:0]  got [$];
  logic [31:0] exp_din = '0;
  logic [31:0] rd_cnt_m = '0;
  logic [31:0] wr_cnt_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    check("mem_din", bus.mem_din, exp_din);
    check("tx_valid", {31'b0, bus.io_tx_valid}, {31'b0, q.size() > 0});
    check("io_full", {31'b0, bus.io_full}, {31'b0, q.size() == DEPTH});
    if (q.size() > 0) check("tx_data", {24'b0, bus.io_tx_data}, {24'b0, q[0]});
`ifdef MEM_RESP_STATS_EN
    check("stat_rd", stat_rd_cnt, rd_cnt_m);
    check("stat_wr", stat_wr_cnt, wr_cnt_m);
`endif
  endtask

  // One bus cycle: drive, predict from pre-edge model state, clock, compare.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic [7:0] d, input logic rdy_sink);
    bit io, do_pop, do_push;
    int idx;
    bus.rdy = r; bus.mem_a = a; bus.mem_wr = w; bus.mem_dout = d; bus.io_tx_ready = rdy_sink;
    io      = (a[17:16] == 2'b11);
    idx     = int'(a[ADDR_W-1:0]);
    do_pop  = (q.size() > 0) && rdy_sink;
    do_push = r && w && io && (a[15:0] == 16'h0000) && (q.size() < DEPTH);
    if (r && !io) begin
      if (w) begin
        ram_m[idx] = d;
        wr_cnt_m++;
      end else begin
        exp_din = {24'b0, ram_m[idx]};
        rd_cnt_m++;
      end
    end else if (r && io && !w) begin
      case (a[15:0])
        16'h0004: exp_din = {30'b0, q.size() == DEPTH, q.size() == 0};
        16'h0008: exp_din = STATS ? rd_cnt_m : 32'd0;
        16'h000C: exp_din = STATS ? wr_cnt_m : 32'd0;
        default:  exp_din = 32'd0;
      endcase
    end
    #1;
    if (do_pop) begin
      check("pop_data", {24'b0, bus.io_tx_data}, {24'b0, q[0]});
      got.push_back(bus.io_tx_data);
      void'(q.pop_front());
    end
    if (do_push) q.push_back(d);
    @(posedge clk);
    #1;
    if (STATS && r && !io && !w && rd_cnt_m == 0) rd_cnt_m = 0;
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    exp_din  = '0;
    rd_cnt_m = '0;
    wr_cnt_m = '0;
  endtask

  initial begin
    bus.rdy = 1'b0; bus.mem_a = '0; bus.mem_wr = 1'b0; bus.mem_dout = '0; bus.io_tx_ready = 1'b0;

    // Reset values
    #12;
    check("rst_din", bus.mem_din, 32'd0);
    check("rst_valid", {31'b0, bus.io_tx_valid}, 32'd0);
    check("rst_full", {31'b0, bus.io_full}, 32'd0);
    check("rst_data", {24'b0, bus.io_tx_data}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Write then read-back with one cycle latency
    step(1, 32'h0000_0010, 1, 8'hA5, 0);
    step(1, 32'h0000_0010, 0, 8'h00, 0);
    check("wr_rd_a5", bus.mem_din, 32'h0000_00A5);

    // Pipelined reads
    step(1, 32'h0, 1, 8'h11, 0);
    step(1, 32'h1, 1, 8'h22, 0);
    step(1, 32'h2, 1, 8'h33, 0);
    step(1, 32'h0, 0, 8'h00, 0); check("pipe0", bus.mem_din, 32'h11);
    step(1, 32'h1, 0, 8'h00, 0); check("pipe1", bus.mem_din, 32'h22);
    step(1, 32'h2, 0, 8'h00, 0); check("pipe2", bus.mem_din, 32'h33);
    step(0, 32'h1, 0, 8'h00, 0); check("rdy0_hold", bus.mem_din, 32'h33);

    // Fill past depth with the sink stalled
    for (int i = 0; i < 17; i++) begin
      step(1, 32'h0003_0000, 1, 8'(i), 0);
      if (i == 15) check("full_after16", {31'b0, bus.io_full}, 32'd1);
    end
    step(1, 32'h0003_0004, 0, 8'h00, 0);
    check("status_full", bus.mem_din, 32'h2);
    got.delete();
    for (int i = 0; i < 16; i++) step(0, 32'h0, 0, 8'h00, 1);
    check("drain_valid", {31'b0, bus.io_tx_valid}, 32'd0);
    check("drain_count", got.size(), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) check("drain_order", {24'b0, got[i]}, i);

    // Push while full and popping: dropped, count 15
    for (int i = 0; i < 16; i++) step(1, 32'h0003_0000, 1, 8'(8'h80 + i), 0);
    step(1, 32'h0003_0000, 1, 8'hEE, 1);
    step(1, 32'h0003_0004, 0, 8'h00, 0);
    check("full_drop_status", bus.mem_din, 32'h0);
    got.delete();
    for (int i = 0; i < 15; i++) step(0, 32'h0, 0, 8'h00, 1);
    check("full_drop_n", got.size(), 32'd15);
    if (got.size() == 15) check("full_drop_last", {24'b0, got[14]}, 32'h8F);

    // Push into empty FIFO with sink ready: no pass-through
    check("pt_pre_valid", {31'b0, bus.io_tx_valid}, 32'd0);
    step(1, 32'h0003_0000, 1, 8'h41, 1);
    check("pt_valid", {31'b0, bus.io_tx_valid}, 32'd1);
    check("pt_data", {24'b0, bus.io_tx_data}, 32'h41);
    step(0, 32'h0, 0, 8'h00, 1);
    check("pt_popped", {31'b0, bus.io_tx_valid}, 32'd0);

    // Asynchronous reset during a read with 5 entries queued
    for (int i = 0; i < 5; i++) step(1, 32'h0003_0000, 1, 8'(8'h50 + i), 0);
    step(1, 32'h0000_0010, 0, 8'h00, 0);
    bus.mem_a = 32'h0000_0001;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("arst_din", bus.mem_din, 32'd0);
    check("arst_valid", {31'b0, bus.io_tx_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    step(1, 32'h0003_0004, 0, 8'h00, 0);
    check("arst_status", bus.mem_din, 32'h1);

    // Access counters (zero when the feature is compiled out)
    step(1, 32'h0000_0000, 0, 8'h00, 0);
    step(1, 32'h0000_0001, 0, 8'h00, 0);
    step(1, 32'h0000_0002, 0, 8'h00, 0);
    step(1, 32'h0000_0020, 1, 8'h77, 0);
    step(1, 32'h0000_0021, 1, 8'h78, 0);
    step(1, 32'h0003_0000, 1, 8'h99, 0);
    step(1, 32'h0003_0008, 0, 8'h00, 1);
    check("stat_rd_io", bus.mem_din, STATS ? 32'd3 : 32'd0);
    step(1, 32'h0003_000C, 0, 8'h00, 1);
    check("stat_wr_io", bus.mem_din, STATS ? 32'd2 : 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic        r, rs;
      int          op, lo;
      r  = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 9);
      lo = $urandom_range(0, 15);
      a  = $urandom;
      if (op <= 3) begin
        a[17] = 1'b0;
        a[16] = 1'($urandom_range(0, 1));
        a[15:0] = 16'(lo);
        if (op <= 1 || !ram_m.exists(int'(a[ADDR_W-1:0])))
          step(r, a, 1, 8'($urandom), rs);
        else
          step(r, a, 0, 8'($urandom), rs);
      end else if (op <= 6) begin
        a[17:16] = 2'b11; a[15:0] = 16'h0000;
        step(r, a, 1, 8'($urandom), rs);
      end else begin
        a[17:16] = 2'b11;
        a[15:0] = 16'(4 * $urandom_range(0, 4));
        step(r, a, op == 9, 8'($urandom), rs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
